// File: rtl/saw_gen.sv
// Phase-accumulator sawtooth oscillator: SAW is the top OUT_W bits of an ACC_W-bit accumulator.
// Optional hard-sync input PHASE_SYNC is enabled by defining SAW_PHASE_SYNC_EN.
module saw_gen #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16  // must not exceed ACC_W
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             LOCKED,
  input  logic [ACC_W-1:0] FREQUENCY,
`ifdef SAW_PHASE_SYNC_EN
  input  logic             PHASE_SYNC,
`endif
  output logic [OUT_W-1:0] SAW
);

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_next;

  // Carry-out is dropped on purpose so the ramp wraps; large tuning words alias freely.
  always_comb begin
    acc_next = acc_reg;
`ifdef SAW_PHASE_SYNC_EN
    if (PHASE_SYNC) begin
      acc_next = '0;
    end else if (LOCKED) begin
      acc_next = acc_reg + FREQUENCY;
    end
`else
    if (LOCKED) begin
      acc_next = acc_reg + FREQUENCY;
    end
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      acc_reg <= '0;
    end else begin
      acc_reg <= acc_next;
    end
  end

  assign SAW = acc_reg[ACC_W-1 -: OUT_W];

endmodule

// File: tb/tb_saw_gen.sv
// Directed-vector bench for saw_gen; expected ramp values are hand-computed from the tuning words.
module tb_saw_gen;

  logic        CLK;
  logic        RESET_N;
  logic        LOCKED;
  logic [31:0] FREQUENCY;
`ifdef SAW_PHASE_SYNC_EN
  logic        PHASE_SYNC;
`endif
  logic [15:0] SAW;

  int checks_total;
  int checks_passed;

  saw_gen #(.ACC_W(32), .OUT_W(16)) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .LOCKED(LOCKED),
    .FREQUENCY(FREQUENCY),
`ifdef SAW_PHASE_SYNC_EN
    .PHASE_SYNC(PHASE_SYNC),
`endif
    .SAW(SAW)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks_total++;
    if (observed === expected) begin
      checks_passed++;
      $display("check %s: SAW=%h", tag, observed);
    end else begin
      $display("FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
    end
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    #2;
    check("reset_async", SAW, 16'h0000);
    RESET_N = 1'b1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    RESET_N   = 1'b0;
    LOCKED    = 1'b1;
    FREQUENCY = 32'h0001_0000;
`ifdef SAW_PHASE_SYNC_EN
    PHASE_SYNC = 1'b0;
`endif
    #3;
    check("reset_initial", SAW, 16'h0000);
    step(1);
    check("reset_held_edge", SAW, 16'h0000);
    RESET_N = 1'b1;

    // Unit step, then asynchronous reset mid-ramp.
    step(1); check("unit_1", SAW, 16'h0001);
    step(1); check("unit_2", SAW, 16'h0002);
    step(1); check("unit_3", SAW, 16'h0003);
    #2;
    RESET_N = 1'b0;
    #1;
    check("reset_midrun_async", SAW, 16'h0000);
    step(1);
    check("reset_midrun_held", SAW, 16'h0000);
    RESET_N = 1'b1;
    step(1); check("restart_1", SAW, 16'h0001);
    step(1); check("restart_2", SAW, 16'h0002);
    step(1); check("restart_3", SAW, 16'h0003);
    step(1); check("restart_4", SAW, 16'h0004);

    // Frequency change keeps phase.
    FREQUENCY = 32'h0002_0000;
    step(1); check("fchange_6", SAW, 16'h0006);
    step(1); check("fchange_8", SAW, 16'h0008);

    // LOCKED hold and resume.
    do_reset();
    FREQUENCY = 32'h0001_0000;
    step(16); check("hold_pre", SAW, 16'h0010);
    LOCKED = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1); check("hold_frozen", SAW, 16'h0010);
    end
    LOCKED = 1'b1;
    step(1); check("hold_resume", SAW, 16'h0011);

    // Fractional: one LSB every two cycles.
    do_reset();
    FREQUENCY = 32'h0000_8000;
    step(1); check("frac_1", SAW, 16'h0000);
    step(1); check("frac_2", SAW, 16'h0001);
    step(1); check("frac_3", SAW, 16'h0001);
    step(1); check("frac_4", SAW, 16'h0002);
    step(1); check("frac_5", SAW, 16'h0002);
    step(1); check("frac_6", SAW, 16'h0003);

    // Nyquist alternation.
    do_reset();
    FREQUENCY = 32'h8000_0000;
    step(1); check("nyq_1", SAW, 16'h8000);
    step(1); check("nyq_2", SAW, 16'h0000);
    step(1); check("nyq_3", SAW, 16'h8000);
    step(1); check("nyq_4", SAW, 16'h0000);

    // Aliased descending ramp, then wrap 0xFFFF -> 0x0000 with carry discarded.
    do_reset();
    FREQUENCY = 32'hFFFF_0000;
    step(1); check("alias_1", SAW, 16'hFFFF);
    step(1); check("alias_2", SAW, 16'hFFFE);
    FREQUENCY = 32'h0001_0000;
    step(1); check("wrap_ffff", SAW, 16'hFFFF);
    step(1); check("wrap_zero", SAW, 16'h0000);
    step(1); check("wrap_one", SAW, 16'h0001);

    // Zero tuning word gives a constant ramp.
    do_reset();
    FREQUENCY = 32'h1234_0000;
    step(1); check("const_load", SAW, 16'h1234);
    FREQUENCY = 32'h0000_0000;
    step(3); check("const_hold", SAW, 16'h1234);

`ifdef SAW_PHASE_SYNC_EN
    LOCKED     = 1'b0;
    PHASE_SYNC = 1'b1;
    step(1); check("sync_clear", SAW, 16'h0000);
    PHASE_SYNC = 1'b0;
    LOCKED     = 1'b1;
    FREQUENCY  = 32'h0001_0000;
    step(1); check("sync_resume", SAW, 16'h0001);
    PHASE_SYNC = 1'b1;
    step(1); check("sync_priority", SAW, 16'h0000);
    PHASE_SYNC = 1'b0;
`endif

    // Finest resolution: first LSB of SAW appears on cycle 65536.
    do_reset();
    FREQUENCY = 32'h0000_0001;
    step(65535); check("fine_65535", SAW, 16'h0000);
    step(1);     check("fine_65536", SAW, 16'h0001);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/saw_gen.md
# saw_gen

Phase-accumulator sawtooth oscillator for the FPGA synth datapath. It integrates a 32-bit frequency tuning word every clock while the clock source is locked, and presents the top 16 accumulator bits as an unsigned rising ramp. The sine generator consumes this ramp as its lookup phase; any other oscillator shape uses it the same way.

## Interface
Parameters:
- ACC_W, 32: phase accumulator and tuning-word width.
- OUT_W, 16: output ramp width. Must satisfy OUT_W ≤ ACC_W.

Ports:
- CLK, input, 1: the single clock; all state changes on its rising edge.
- RESET_N, input, 1: asynchronous, active-low reset.
- LOCKED, input, 1: clock-source lock flag and accumulate enable; 1 advances the phase.
- FREQUENCY, input, ACC_W: unsigned phase increment per clock (tuning word).
- SAW, output, OUT_W: unsigned ramp, equal to accumulator bits [ACC_W-1 : ACC_W-OUT_W].
- PHASE_SYNC, input, 1: only present with SAW_PHASE_SYNC_EN; synchronous phase clear.

## Operation
- Internal register ACC is ACC_W bits wide and unsigned.
- Each rising CLK with LOCKED=1: ACC <= ACC + FREQUENCY, modulo 2^ACC_W.
  - The carry-out is discarded, so the ramp wraps naturally from 0xFFFF to 0x0000.
- Each rising CLK with LOCKED=0: ACC holds its value, so SAW freezes (no reset to zero).
- SAW is driven directly from ACC[ACC_W-1 : ACC_W-OUT_W]. There is no combinational path from FREQUENCY or LOCKED to SAW.
- Output frequency: f_out = FREQUENCY × f_CLK / 2^ACC_W.
  - Resolution is f_CLK / 2^32.
  - FREQUENCY = 0 produces a constant SAW.
- FREQUENCY ≥ 2^(ACC_W-1) aliases, producing a descending or folded ramp. This is legal and not flagged.
- FREQUENCY is sampled every enabled cycle. It may change on any cycle, with no phase discontinuity beyond the new increment.

## Timing
- Reset: RESET_N low asynchronously forces ACC = 0 and SAW = 0.
  - This holds regardless of CLK and LOCKED.
  - The first update happens at the first rising CLK after RESET_N is sampled high.
- Latency: a FREQUENCY or LOCKED value present before rising edge n is reflected in SAW immediately after edge n, i.e. one cycle.
- The accumulator add is a single-cycle, full-width carry chain. It must close timing at the synth clock; no pipelining.
- LOCKED deasserting mid-ramp: SAW holds its last value exactly. When LOCKED is reasserted, accumulation resumes from the held phase.
- Reset during operation: the ramp restarts from 0 and no prior phase is retained.

## Configuration
- SAW_PHASE_SYNC_EN defined:
  - Adds the PHASE_SYNC input.
  - A rising CLK with PHASE_SYNC=1 loads ACC <= 0. This takes priority over LOCKED and FREQUENCY.
  - Use it for oscillator hard-sync and note-on phase alignment.
- SAW_PHASE_SYNC_EN undefined: the port is absent and ACC is cleared only by RESET_N.

## Test plan
- Reset: RESET_N=0 with LOCKED=1 and FREQUENCY=0x00010000 -> SAW=0x0000 asynchronously. After release, SAW=0x0001 after the first edge.
- Unit step: FREQUENCY=0x00010000, LOCKED=1 -> SAW goes 1, 2, 3, … one per cycle. After 65536 cycles it wraps 0xFFFF -> 0x0000.
- Fractional and Nyquist:
  - FREQUENCY=0x00008000 -> SAW increments by 1 every 2 cycles.
  - FREQUENCY=0x80000000 -> SAW alternates 0x8000, 0x0000.
  - FREQUENCY=0x00000001 -> SAW first becomes 0x0001 on cycle 65536.
- LOCKED hold: run FREQUENCY=0x00010000 to SAW=0x0010, drop LOCKED for 5 cycles -> SAW stays 0x0010. Reassert -> next edge SAW=0x0011.
- Frequency change: switch FREQUENCY 0x00010000 -> 0x00020000 when SAW=0x0004 -> next values 0x0006, 0x0008, with no reset of phase.
- With SAW_PHASE_SYNC_EN: PHASE_SYNC=1 for one cycle with LOCKED=0 and SAW=0x1234 -> SAW=0x0000 after that edge. With LOCKED=1 and FREQUENCY=0x00010000, the following edge gives 0x0001.
